// File: rtl/invaders_pkg.sv
// Shared grid geometry, game state encoding and drawer colours for the invaders game.
package invaders_pkg;

    localparam int GRID_COLS = 20;
    localparam int GRID_ROWS = 15;
    localparam int SHIP_ROW  = 13;

    localparam logic [4:0] SHIP_START_X = 5'd9;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        WON  = 2'd1,
        LOST = 2'd2
    } game_state_t;

    localparam logic [11:0] COLOR_BG      = 12'h000;
    localparam logic [11:0] COLOR_SHIP    = 12'h0F0;
    localparam logic [11:0] COLOR_INVADER = 12'hFFF;
    localparam logic [11:0] COLOR_BULLET  = 12'hFF0;

endpackage

// File: rtl/invaders_game_logic_if.sv
// Frame tick, player buttons and the grid-coordinate game state handed to the sprite drawer.
interface invaders_game_logic_if;
    import invaders_pkg::*;

    logic                 tick;
    logic                 btn_left;
    logic                 btn_right;
    logic                 btn_fire;
    logic [GRID_COLS-1:0] invaders_array;
    logic [4:0]           invaders_line;
    logic [4:0]           ship_x;
    logic [4:0]           bullet_x;
    logic [3:0]           bullet_y;
    logic                 bullet_flying;
    logic                 game_won;
    logic                 game_lost;

    modport master (
        output tick, btn_left, btn_right, btn_fire,
        input  invaders_array, invaders_line, ship_x, bullet_x, bullet_y,
               bullet_flying, game_won, game_lost
    );

    modport slave (
        input  tick, btn_left, btn_right, btn_fire,
        output invaders_array, invaders_line, ship_x, bullet_x, bullet_y,
               bullet_flying, game_won, game_lost
    );

endinterface

// File: rtl/tick_divider.sv
// Counts frame ticks 0..DIV-1 and strobes step on the tick that wraps the count.
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic tick,
    output logic step
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign step = en && tick && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (en && tick) begin
            cnt_d = step ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/invaders_game_logic.sv
// Space Invaders game-state engine: formation march, ship, bullet and hit detection per frame tick.
// States: PLAY advances the game; WON and LOST freeze every output until reset.
module invaders_game_logic
    import invaders_pkg::*;
#(
    parameter int          SHIP_DIV    = 4,
    parameter int          BULLET_DIV  = 2,
    parameter int          INVADER_DIV = 30,
    parameter logic [19:0] START_ARRAY = 20'h0FFF0,
    parameter int          START_LINE  = 1,
    parameter int          FIRE_ROW    = 12,
    parameter int          LOSE_ROW    = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    invaders_game_logic_if.slave  game_if
);

    localparam logic [4:0] SHIP_MAX = 5'(GRID_COLS - 1);

    game_state_t          state_q, state_d;
    logic [GRID_COLS-1:0] array_q, array_d, array_hit;
    logic [4:0]           line_q, line_d;
    logic [4:0]           ship_q, ship_d;
    logic [4:0]           bx_q, bx_d;
    logic [3:0]           by_q, by_d;
    logic                 fly_q, fly_d;
    logic                 dir_left_q, dir_left_d;
    logic                 won_q, won_d;
    logic                 lost_q, lost_d;

    logic play, hit, at_edge;
    logic step_ship, step_bullet, step_march;

    assign play = (state_q == PLAY);
    assign hit  = fly_q && !line_q[4] && (by_q == line_q[3:0]) && array_q[bx_q];

    tick_divider #(.DIV(SHIP_DIV)) u_ship_div (
        .clk(clk), .reset(reset), .en(play), .tick(game_if.tick), .step(step_ship)
    );

    tick_divider #(.DIV(BULLET_DIV)) u_bullet_div (
        .clk(clk), .reset(reset), .en(play), .tick(game_if.tick), .step(step_bullet)
    );

    tick_divider #(.DIV(INVADER_DIV)) u_march_div (
        .clk(clk), .reset(reset), .en(play), .tick(game_if.tick), .step(step_march)
    );

    always_comb begin
        state_d    = state_q;
        array_d    = array_q;
        array_hit  = array_q;
        line_d     = line_q;
        ship_d     = ship_q;
        bx_d       = bx_q;
        by_d       = by_q;
        fly_d      = fly_q;
        dir_left_d = dir_left_q;
        won_d      = won_q;
        lost_d     = lost_q;
        at_edge    = 1'b0;

        if (play) begin
            if (step_ship) begin
                if (game_if.btn_left && !game_if.btn_right && ship_q != 5'd0) begin
                    ship_d = ship_q - 5'd1;
                end else if (game_if.btn_right && !game_if.btn_left && ship_q != SHIP_MAX) begin
                    ship_d = ship_q + 5'd1;
                end
            end

            // A hit outranks both launch and bullet motion in the same cycle.
            if (hit) begin
                array_hit[bx_q] = 1'b0;
                fly_d           = 1'b0;
            end else if (game_if.tick && !fly_q && game_if.btn_fire) begin
                bx_d  = ship_q;
                by_d  = 4'(FIRE_ROW);
                fly_d = 1'b1;
            end else if (step_bullet && fly_q) begin
                if (by_q == 4'd0) begin
                    fly_d = 1'b0;
                end else begin
                    by_d = by_q - 4'd1;
                end
            end

            array_d = array_hit;
            if (step_march) begin
                at_edge = dir_left_q ? array_hit[0] : array_hit[GRID_COLS-1];
                if (at_edge) begin
                    line_d     = line_q + 5'd1;
                    dir_left_d = !dir_left_q;
                end else if (dir_left_q) begin
                    array_d = array_hit >> 1;
                end else begin
                    array_d = array_hit << 1;
                end
            end

            if (array_d == '0) begin
                state_d = WON;
                won_d   = 1'b1;
            end else if (line_d >= 5'(LOSE_ROW)) begin
                state_d = LOST;
                lost_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= PLAY;
            array_q    <= START_ARRAY;
            line_q     <= 5'(START_LINE);
            ship_q     <= SHIP_START_X;
            bx_q       <= '0;
            by_q       <= '0;
            fly_q      <= 1'b0;
            dir_left_q <= 1'b0;
            won_q      <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            array_q    <= array_d;
            line_q     <= line_d;
            ship_q     <= ship_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            fly_q      <= fly_d;
            dir_left_q <= dir_left_d;
            won_q      <= won_d;
            lost_q     <= lost_d;
        end
    end

    assign game_if.invaders_array = array_q;
    assign game_if.invaders_line  = line_q;
    assign game_if.ship_x         = ship_q;
    assign game_if.bullet_x       = bx_q;
    assign game_if.bullet_y       = by_q;
    assign game_if.bullet_flying  = fly_q;
    assign game_if.game_won       = won_q;
    assign game_if.game_lost      = lost_q;

endmodule

// File: tb/tb_invaders_game_logic.sv
// Bench for invaders_game_logic: three instances (slow march, fast march, single invader).
module tb_invaders_game_logic;
    import invaders_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    invaders_game_logic_if if_a ();
    invaders_game_logic_if if_b ();
    invaders_game_logic_if if_c ();

    invaders_game_logic #(
        .SHIP_DIV(4), .BULLET_DIV(2), .INVADER_DIV(1000), .START_ARRAY(20'h0FFF0)
    ) dut_a (.clk(clk), .reset(reset), .game_if(if_a));

    invaders_game_logic #(
        .SHIP_DIV(4), .BULLET_DIV(2), .INVADER_DIV(1), .START_ARRAY(20'h0FFF0)
    ) dut_b (.clk(clk), .reset(reset), .game_if(if_b));

    invaders_game_logic #(
        .SHIP_DIV(4), .BULLET_DIV(2), .INVADER_DIV(1000), .START_ARRAY(20'h00010)
    ) dut_c (.clk(clk), .reset(reset), .game_if(if_c));

    typedef struct packed {
        logic [19:0] arr;
        logic [4:0]  line;
        logic [4:0]  ship;
        logic [4:0]  bx;
        logic [3:0]  by;
        logic        fly;
        logic        won;
        logic        lost;
    } obs_t;

    typedef struct {
        logic l;
        logic r;
        logic f;
        obs_t exp;
    } vec_t;

    localparam int NVEC = 84;

    vec_t vecs[NVEC];
    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   lost_at;

    function automatic obs_t mk(input logic [19:0] arr, input int line, input int ship,
                                input int bx, input int by, input logic fly,
                                input logic won, input logic lost);
        obs_t o;
        o.arr  = arr;
        o.line = 5'(line);
        o.ship = 5'(ship);
        o.bx   = 5'(bx);
        o.by   = 4'(by);
        o.fly  = fly;
        o.won  = won;
        o.lost = lost;
        return o;
    endfunction

    function automatic obs_t snap(input int u);
        obs_t o;
        case (u)
            0: o = {if_a.invaders_array, if_a.invaders_line, if_a.ship_x, if_a.bullet_x,
                    if_a.bullet_y, if_a.bullet_flying, if_a.game_won, if_a.game_lost};
            1: o = {if_b.invaders_array, if_b.invaders_line, if_b.ship_x, if_b.bullet_x,
                    if_b.bullet_y, if_b.bullet_flying, if_b.game_won, if_b.game_lost};
            default: o = {if_c.invaders_array, if_c.invaders_line, if_c.ship_x, if_c.bullet_x,
                    if_c.bullet_y, if_c.bullet_flying, if_c.game_won, if_c.game_lost};
        endcase
        return o;
    endfunction

    // Ship walks left 40 ticks, right 8, both 8, then fires at empty column 2.
    function automatic vec_t build_vec(input int i);
        vec_t v;
        int   shp;
        int   k;
        v.l = (i <= 40) || (i >= 49 && i <= 56);
        v.r = (i >= 41 && i <= 56);
        v.f = (i >= 57 && i <= 82);
        if (i <= 40)      shp = (9 - i / 4 < 0) ? 0 : 9 - i / 4;
        else if (i <= 48) shp = (i - 40) / 4;
        else              shp = 2;
        k = i - 56;
        if (k < 1)        v.exp = mk(20'h0FFF0, 1, shp, 0, 0, 1'b0, 1'b0, 1'b0);
        else if (k <= 24) v.exp = mk(20'h0FFF0, 1, shp, 2, 12 - k / 2, 1'b1, 1'b0, 1'b0);
        else if (k == 25) v.exp = mk(20'h0FFF0, 1, shp, 2, 0, 1'b1, 1'b0, 1'b0);
        else              v.exp = mk(20'h0FFF0, 1, shp, 2, 0, 1'b0, 1'b0, 1'b0);
        return v;
    endfunction

    task automatic drive(input int u, input logic t, input logic l, input logic r, input logic f);
        case (u)
            0: begin if_a.tick = t; if_a.btn_left = l; if_a.btn_right = r; if_a.btn_fire = f; end
            1: begin if_b.tick = t; if_b.btn_left = l; if_b.btn_right = r; if_b.btn_fire = f; end
            default: begin if_c.tick = t; if_c.btn_left = l; if_c.btn_right = r; if_c.btn_fire = f; end
        endcase
    endtask

    task automatic do_tick(input int u, input logic l, input logic r, input logic f);
        drive(u, 1'b1, l, r, f);
        @(negedge clk);
        drive(u, 1'b0, l, r, f);
    endtask

    task automatic do_reset(input logic tick_during_reset);
        reset     = 1'b1;
        if_a.tick = tick_during_reset;
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        if_a.tick = 1'b0;
    endtask

    task automatic chk(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got arr=%05h line=%0d ship=%0d bx=%0d by=%0d fly=%b won=%b lost=%b, want arr=%05h line=%0d ship=%0d bx=%0d by=%0d fly=%b won=%b lost=%b",
                     name, act.arr, act.line, act.ship, act.bx, act.by, act.fly, act.won, act.lost,
                     exp.arr, exp.line, exp.ship, exp.bx, exp.by, exp.fly, exp.won, exp.lost);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 1; i <= NVEC; i++) vecs[i-1] = build_vec(i);

        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(2, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        do_reset(1'b0);
        chk("reset_a", snap(0), mk(20'h0FFF0, 1, 9, 0, 0, 1'b0, 1'b0, 1'b0));
        chk("reset_b", snap(1), mk(20'h0FFF0, 1, 9, 0, 0, 1'b0, 1'b0, 1'b0));
        chk("reset_c", snap(2), mk(20'h00010, 1, 9, 0, 0, 1'b0, 1'b0, 1'b0));

        for (int i = 1; i <= 100; i++) begin
            do_tick(0, 1'b0, 1'b0, 1'b0);
            if (i % 25 == 0)
                chk($sformatf("idle_stable_%0d", i), snap(0), mk(20'h0FFF0, 1, 9, 0, 0, 1'b0, 1'b0, 1'b0));
        end

        // A tick held through reset must not advance any divider.
        do_reset(1'b1);
        chk("reset_with_tick", snap(0), mk(20'h0FFF0, 1, 9, 0, 0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < NVEC; i++) begin
            exp_q.push_back(vecs[i].exp);
            do_tick(0, vecs[i].l, vecs[i].r, vecs[i].f);
            chk($sformatf("vec%0d", i + 1), snap(0), exp_q.pop_front());
        end
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);

        do_reset(1'b0);
        do_tick(0, 1'b0, 1'b0, 1'b1);
        chk("launch_9", snap(0), mk(20'h0FFF0, 1, 9, 9, 12, 1'b1, 1'b0, 1'b0));
        repeat (21) do_tick(0, 1'b0, 1'b0, 1'b0);
        chk("bullet_row1", snap(0), mk(20'h0FFF0, 1, 9, 9, 1, 1'b1, 1'b0, 1'b0));
        do_tick(0, 1'b0, 1'b0, 1'b1);
        chk("hit_over_fire", snap(0), mk(20'h0FDF0, 1, 9, 9, 1, 1'b0, 1'b0, 1'b0));
        do_tick(0, 1'b0, 1'b0, 1'b1);
        chk("relaunch_no_step", snap(0), mk(20'h0FDF0, 1, 9, 9, 12, 1'b1, 1'b0, 1'b0));
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int t = 1; t <= 6; t++) begin
            do_tick(1, 1'b0, 1'b0, 1'b0);
            if (t == 4) chk("march_right4", snap(1), mk(20'hFFF00, 1, 9, 0, 0, 1'b0, 1'b0, 1'b0));
            if (t == 5) chk("march_drop2", snap(1), mk(20'hFFF00, 2, 9, 0, 0, 1'b0, 1'b0, 1'b0));
            if (t == 6) chk("march_left1", snap(1), mk(20'h7FF80, 2, 9, 0, 0, 1'b0, 1'b0, 1'b0));
        end
        lost_at = 0;
        for (int t = 7; t <= 200 && lost_at == 0; t++) begin
            do_tick(1, 1'b0, 1'b0, 1'b0);
            if (t == 14) chk("march_drop3", snap(1), mk(20'h00FFF, 3, 9, 0, 0, 1'b0, 1'b0, 1'b0));
            if (if_b.game_lost) lost_at = t;
        end
        chk_int("lost_tick", lost_at, 95);
        chk("lost_state", snap(1), mk(20'hFFF00, 12, 9, 0, 0, 1'b0, 1'b0, 1'b1));
        repeat (10) do_tick(1, 1'b1, 1'b0, 1'b1);
        chk("lost_frozen", snap(1), mk(20'hFFF00, 12, 9, 0, 0, 1'b0, 1'b0, 1'b1));

        repeat (20) do_tick(2, 1'b1, 1'b0, 1'b0);
        chk("c_ship_at_4", snap(2), mk(20'h00010, 1, 4, 0, 0, 1'b0, 1'b0, 1'b0));
        do_tick(2, 1'b0, 1'b0, 1'b1);
        chk("c_launch", snap(2), mk(20'h00010, 1, 4, 4, 12, 1'b1, 1'b0, 1'b0));
        repeat (21) do_tick(2, 1'b0, 1'b0, 1'b0);
        chk("c_row1", snap(2), mk(20'h00010, 1, 4, 4, 1, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        chk("c_won", snap(2), mk(20'h00000, 1, 4, 4, 1, 1'b0, 1'b1, 1'b0));
        for (int i = 1; i <= 50; i++) begin
            do_tick(2, 1'(i % 2), 1'(i % 3 == 0), 1'b1);
            if (i % 10 == 0)
                chk($sformatf("won_frozen_%0d", i), snap(2), mk(20'h00000, 1, 4, 4, 1, 1'b0, 1'b1, 1'b0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/invaders_game_logic.md
Name: invaders_game_logic

Overview:
- Game-state engine for Space Invaders; sits directly upstream of the sprite drawer (format_vga).
- Owns the invader formation, ship position and bullet, and advances them on a once-per-frame tick.
- Outputs are grid coordinates: 20 columns × 15 rows of 32×32-pixel cells.
- Output widths and meanings match the drawer's inputs, so the outputs wire straight across.

Parameters:
SHIP_DIV, 4, frame ticks per ship move step
BULLET_DIV, 2, frame ticks per bullet step
INVADER_DIV, 30, frame ticks per formation march step
START_ARRAY, 20'h0FFF0, invader occupancy at reset (bit i = column i)
START_LINE, 1, invader row at reset
FIRE_ROW, 12, bullet row on launch (row directly above the ship, which is fixed at row 13)
LOSE_ROW, 12, invader row that ends the game as lost

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tick  in  1  one-cycle pulse per video frame (from the sync generator, at vsync)
btn_left  in  1  move ship left (level, already debounced)
btn_right  in  1  move ship right (level)
btn_fire  in  1  fire request (level)
invaders_array  out  20  live invaders per column in the current line
invaders_line  out  5  grid row of the formation, 0..14
ship_x  out  5  ship column, 0..19
bullet_x  out  5  bullet column
bullet_y  out  4  bullet row
bullet_flying  out  1  bullet is valid and is drawn
game_won  out  1  formation destroyed (sticky)
game_lost  out  1  formation reached LOSE_ROW (sticky)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset, and has priority over everything.
- Reset values:
  - invaders_array = START_ARRAY; invaders_line = START_LINE; ship_x = 9.
  - bullet_x = 0; bullet_y = 0; bullet_flying = 0.
  - game_won = 0; game_lost = 0; march direction = right (increasing column); all divider counters = 0.
- All outputs are registered. No combinational path from any input to any output.
- FSM states: PLAY, WON, LOST.
  - Reset enters PLAY.
  - WON and LOST hold every output frozen until reset; in these states tick and buttons are ignored.
- Dividers:
  - Each divider counts tick pulses 0..DIV-1.
  - Its step strobe is tick && count == DIV-1; the counter then wraps to 0.
  - Counters advance only in PLAY.
- Ship step (PLAY):
  - btn_left alone and ship_x > 0: decrement.
  - btn_right alone and ship_x < 19: increment.
  - Both buttons or neither: hold. Saturates at 0 and 19.
- Hit check (PLAY), evaluated every cycle on registered state:
  - Hit condition: bullet_flying && invaders_line[4] == 0 && bullet_y == invaders_line[3:0] && invaders_array[bullet_x].
  - On a hit, in the next cycle: clear invaders_array[bullet_x] and set bullet_flying = 0.
  - A hit has priority over the bullet step and over launch in the same cycle.
- Bullet (PLAY, no hit this cycle):
  - Launch on tick when !bullet_flying && btn_fire: bullet_x = ship_x (pre-move value), bullet_y = FIRE_ROW, bullet_flying = 1.
  - Launch suppresses any bullet step in the same cycle.
  - Otherwise on a bullet step while flying: if bullet_y == 0, clear bullet_flying (leaves the screen); else decrement bullet_y.
  - Firing while a bullet is flying is ignored.
- Formation march (PLAY, on march step); uses the array after any same-cycle hit clear:
  - Moving right with bit 19 set, or moving left with bit 0 set: invaders_line += 1, flip direction, no shift.
  - Otherwise: shift the array one column in the current direction.
- End of game:
  - If the updated array == 0: enter WON, game_won = 1.
  - Else if the updated invaders_line >= LOSE_ROW: enter LOST, game_lost = 1.
  - WON is checked first; it wins over LOST when both become true in the same cycle.
- A tick that arrives in the same cycle as reset is ignored.

Decomposition:
- Package invaders_pkg holds:
  - grid constants: GRID_COLS = 20, GRID_ROWS = 15, SHIP_ROW = 13;
  - the game_state_t enum {PLAY, WON, LOST};
  - the colour constants shared with the drawer.
- One sub-module, tick_divider (parameter DIV; ports clk, reset, en, tick, step).
  - Instantiated three times: ship, bullet, march.
  - en is tied to the PLAY state.

Test Plan:
1. Reset → invaders_array = 0x0FFF0, invaders_line = 1, ship_x = 9, bullet_flying = 0, game_won = 0, game_lost = 0, all stable over 100 ticks with INVADER_DIV raised to a large value.
2. Hold btn_left for 40 ticks with SHIP_DIV = 4 → ship_x walks 9→0 and stays at 0. Then hold both buttons → ship_x holds.
3. Ship at 9, pulse btn_fire on a tick → bullet at (9, 12), flying. With BULLET_DIV = 2 it reaches row 1 (the formation row) and hits → bit 9 cleared (array 0x0FDF0), flying = 0 on the next cycle.
4. Fire at column 2 (empty) → bullet reaches y = 0, then the next step clears bullet_flying. The array is unchanged.
5. March from reset with INVADER_DIV = 1 → 4 right shifts (0xFFF00), then a drop to line 2 with direction flipped, then a left shift (0x7FF80).
6. Force the array to the single bit 0x00010 and shoot it → game_won = 1, then outputs are frozen through 50 ticks. Separately, let the formation march unimpeded → game_lost = 1 when invaders_line reaches 12.
